// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the 5-stage pipeline hazard sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_unit_pkg;

    // Sequencer states, 2-bit encoded.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hcu_state_e;

    // Operand source select latched into ID/EX.
    localparam logic [1:0] FWD_REG   = 2'd0;  // register file
    localparam logic [1:0] FWD_EXMEM = 2'd1;  // EX/MEM result
    localparam logic [1:0] FWD_MEMWB = 2'd2;  // MEM/WB result

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Operand forwarding select for one source register of the ID instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
//
// Ports: i_src (source reg), i_ex_rd/i_ex_regwrite (EX producer),
//        i_mem_rd/i_mem_regwrite (MEM producer), o_fwd (FWD_* select).
module hazard_ctrl_unit_fwd_select
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_regwrite,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_regwrite,
    output logic [1:0]            o_fwd
);

    logic w_ex_hit;
    logic w_mem_hit;

    // Register 0 is hardwired, so a write to it is never a real producer.
    assign w_ex_hit  = i_ex_regwrite  && (i_ex_rd  != '0) && (i_ex_rd  == i_src);
    assign w_mem_hit = i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_src);

    // The younger producer (EX) holds the most recent value and wins.
    always_comb begin
        o_fwd = FWD_REG;
        if (w_ex_hit) begin
            o_fwd = FWD_EXMEM;
        end else if (w_mem_hit) begin
            o_fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes, HLT drain/halt, forwarding selects.
// Latency: control outputs are combinational on current state + ID/EX/MEM info; state advances per clk.
// Backpressure: stalls PC and IF/ID via enables; bubbles via ID/EX clear; HALTED freezes everything.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs/id_rt/id_uses_*      sources of the instruction in ID; id_hlt marks HLT
//   ex_rd/ex_regwrite/ex_memread   destination info of the instruction in EX
//   mem_rd/mem_regwrite        destination info of the instruction in MEM
//   mem_branch_taken           redirect resolved in MEM
//   pc_write_en, if_id_write_en, if_id_clear, id_ex_write_en, id_ex_clear, ex_mem_clear
//   forwardA/forwardB          operand selects (FWD_* encoding)
//   halted                     core halted (sticky until reset)
//   stall_cnt/flush_cnt        saturating event counters, present only with HAZARD_PERF_CNT_EN
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W        = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_hlt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic                  mem_branch_taken,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_clear,
    output logic                  id_ex_write_en,
    output logic                  id_ex_clear,
    output logic                  ex_mem_clear,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    localparam int CNT_MAX = (DRAIN_CYCLES > LOAD_STALL_CYCLES) ? DRAIN_CYCLES : LOAD_STALL_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    hcu_state_e       r_state;
    hcu_state_e       w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;

    logic w_load_use;
    logic w_bubble;
    logic w_pc_we;
    logic w_if_id_we;
    logic w_if_id_clr;
    logic w_id_ex_we;
    logic w_id_ex_clr;
    logic w_ex_mem_clr;

    // ------------------------------------------------------------------
    // Forwarding selects
    // ------------------------------------------------------------------
    hazard_ctrl_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .i_src          (id_rs),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .o_fwd          (forwardA)
    );

    hazard_ctrl_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .i_src          (id_rt),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .o_fwd          (forwardB)
    );

    // A load in EX cannot forward in time; only real reads of a nonzero reg count.
    assign w_load_use = ex_memread && (ex_rd != '0) &&
                        ((id_uses_rs && (ex_rd == id_rs)) ||
                         (id_uses_rt && (ex_rd == id_rt)));

    // ------------------------------------------------------------------
    // Control outputs and next state. Outputs are Mealy so that a hazard
    // seen in ID takes effect in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_bubble     = 1'b0;
        w_pc_we      = 1'b1;
        w_if_id_we   = 1'b1;
        w_if_id_clr  = 1'b0;
        w_id_ex_we   = 1'b1;
        w_id_ex_clr  = 1'b0;
        w_ex_mem_clr = 1'b0;

        if (r_state == HALTED) begin
            w_pc_we    = 1'b0;
            w_if_id_we = 1'b0;
            w_id_ex_we = 1'b0;
        end else if (mem_branch_taken) begin
            // Everything younger than MEM is on the wrong path, including
            // any pending stall or an HLT being drained.
            w_if_id_clr  = 1'b1;
            w_id_ex_clr  = 1'b1;
            w_ex_mem_clr = 1'b1;
            w_nxt_state  = RUN;
            w_nxt_cnt    = '0;
        end else if (r_state == DRAIN) begin
            // Fetch frozen and front end emptied; EX/MEM keeps retiring.
            w_pc_we     = 1'b0;
            w_if_id_clr = 1'b1;
            w_id_ex_clr = 1'b1;
            if (r_cnt <= CNT_ONE) begin
                w_nxt_state = HALTED;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt = r_cnt - CNT_ONE;
            end
        end else if (id_hlt) begin
            w_pc_we     = 1'b0;
            w_if_id_clr = 1'b1;
            w_id_ex_clr = 1'b1;
            if (DRAIN_CYCLES == 0) begin
                w_nxt_state = HALTED;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_state = DRAIN;
                w_nxt_cnt   = DRAIN_LOAD;
            end
        end else if (r_state == STALL) begin
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_id_ex_clr = 1'b1;
            w_bubble    = 1'b1;
            if (r_cnt <= CNT_ONE) begin
                w_nxt_state = RUN;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt = r_cnt - CNT_ONE;
            end
        end else if (w_load_use) begin
            // First bubble is inserted right away; extra ones come from STALL.
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_id_ex_clr = 1'b1;
            w_bubble    = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_nxt_state = STALL;
                w_nxt_cnt   = STALL_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign pc_write_en    = w_pc_we;
    assign if_id_write_en = w_if_id_we;
    assign if_id_clear    = w_if_id_clr;
    assign id_ex_write_en = w_id_ex_we;
    assign id_ex_clear    = w_id_ex_clr;
    assign ex_mem_clear   = w_ex_mem_clr;
    assign halted         = (r_state == HALTED);

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_bubble && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (mem_branch_taken && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: two instances (1 and 3 load-use bubbles)
// driven by shared directed and random stimulus, compared against a behavioural model.
// Perf counters are checked as well when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_unit;
    import hazard_ctrl_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rs, id_uses_rt, id_hlt;
    logic       ex_regwrite, ex_memread, mem_regwrite, mem_branch_taken;

    logic [1:0] pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_clr, hlt_o;
    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic [15:0] scnt [2];
    logic [15:0] fcnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_hlt(id_hlt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_branch_taken(mem_branch_taken),
        .pc_write_en(pc_we[0]), .if_id_write_en(ifid_we[0]), .if_id_clear(ifid_clr[0]),
        .id_ex_write_en(idex_we[0]), .id_ex_clear(idex_clr[0]), .ex_mem_clear(exmem_clr[0]),
        .forwardA(fa[0]), .forwardB(fb[0]), .halted(hlt_o[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
`endif
    );

    hazard_ctrl_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_hlt(id_hlt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_branch_taken(mem_branch_taken),
        .pc_write_en(pc_we[1]), .if_id_write_en(ifid_we[1]), .if_id_clear(ifid_clr[1]),
        .id_ex_write_en(idex_we[1]), .id_ex_clear(idex_clr[1]), .ex_mem_clear(exmem_clr[1]),
        .forwardA(fa[1]), .forwardB(fb[1]), .halted(hlt_o[1])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
`endif
    );

    // ---------------- behavioural model ----------------
    localparam int A_NORM = 0, A_FLUSH = 1, A_DRAIN = 2, A_HLT = 3,
                   A_STALL = 4, A_LOADUSE = 5, A_HALTED = 6;
    localparam int DRAIN_N = 3;

    int lsc [2] = '{1, 3};
    int m_stall [2];     // extra bubbles still owed
    int m_drain [2];     // drain cycles left (0 = not draining)
    bit m_halted [2];
    int m_scnt [2];
    int m_fcnt [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_drain[k] = 0; m_halted[k] = 0;
            m_scnt[k] = 0; m_fcnt[k] = 0;
        end
    endtask

    function automatic int decide(int k);
        bit lu;
        lu = ex_memread && (ex_rd != 0) &&
             ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
        if (m_halted[k])      return A_HALTED;
        if (mem_branch_taken) return A_FLUSH;
        if (m_drain[k] > 0)   return A_DRAIN;
        if (id_hlt)           return A_HLT;
        if (m_stall[k] > 0)   return A_STALL;
        if (lu)               return A_LOADUSE;
        return A_NORM;
    endfunction

    // {pc_we, ifid_we, idex_we, ifid_clr, idex_clr, exmem_clr, halted}
    function automatic logic [6:0] exp_vec(int a);
        case (a)
            A_HALTED:           return 7'b0000001;
            A_FLUSH:            return 7'b1111110;
            A_DRAIN, A_HLT:     return 7'b0111100;
            A_STALL, A_LOADUSE: return 7'b0010100;
            default:            return 7'b1110000;
        endcase
    endfunction

    task automatic advance(int k, int a);
        case (a)
            A_FLUSH:   begin m_stall[k] = 0; m_drain[k] = 0; end
            A_DRAIN:   begin m_drain[k]--; if (m_drain[k] == 0) m_halted[k] = 1; end
            A_HLT:     begin m_stall[k] = 0; m_drain[k] = DRAIN_N; end
            A_STALL:   m_stall[k]--;
            A_LOADUSE: m_stall[k] = lsc[k] - 1;
            default:   ;
        endcase
        if ((a == A_STALL || a == A_LOADUSE) && m_scnt[k] < 65535) m_scnt[k]++;
        if (mem_branch_taken && m_fcnt[k] < 65535) m_fcnt[k]++;
    endtask

    function automatic logic [1:0] fwd_exp(logic [3:0] src);
        if (ex_regwrite && ex_rd != 0 && ex_rd == src)   return 2'd1;
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [6:0] obs_vec(int k);
        return {pc_we[k], ifid_we[k], idex_we[k], ifid_clr[k], idex_clr[k], exmem_clr[k], hlt_o[k]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag, input int a0, input int a1);
        int a [2];
        a[0] = a0; a[1] = a1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_ctl_L%0d", tag, lsc[k]), 16'(obs_vec(k)), 16'(exp_vec(a[k])));
            chk($sformatf("%s_fwdA_L%0d", tag, lsc[k]), 16'(fa[k]), 16'(fwd_exp(id_rs)));
            chk($sformatf("%s_fwdB_L%0d", tag, lsc[k]), 16'(fb[k]), 16'(fwd_exp(id_rt)));
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("%s_scnt_L%0d", tag, lsc[k]), scnt[k], 16'(m_scnt[k]));
            chk($sformatf("%s_fcnt_L%0d", tag, lsc[k]), fcnt[k], 16'(m_fcnt[k]));
`endif
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag);
        int a0, a1;
        #1;
        a0 = decide(0);
        a1 = decide(1);
        check_now(tag, a0, a1);
        @(posedge clk);
        advance(0, a0);
        advance(1, a1);
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_hlt = 1'b0;
        ex_rd = 4'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 4'd0; mem_regwrite = 1'b0; mem_branch_taken = 1'b0;
    endtask

    // Asserts reset mid-cycle and checks outputs before the next clock edge.
    task automatic do_reset(input string tag);
        set_idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_now(tag, A_NORM, A_NORM);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        model_reset();
        do_reset("reset");

        // Forwarding priority: EX over MEM, then MEM when EX targets r0.
        ex_regwrite = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; mem_rd = 4'd5; mem_regwrite = 1'b1;
        #1 chk("t1_fwdA_ex", 16'(fa[0]), 16'(FWD_EXMEM));
        step("t1a");
        ex_rd = 4'd0;
        #1 chk("t1_fwdA_mem", 16'(fa[0]), 16'(FWD_MEMWB));
        step("t1b");
        set_idle();

        // Load-use on rt: one bubble for L1, three for L3.
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 4'd3; id_rt = 4'd3; id_uses_rt = 1'b1;
        step("t2_hz");
        set_idle();
        for (int i = 0; i < 4; i++) step("t2_after");

        // Long stall aborted by a taken branch in its second cycle.
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 4'd3; id_rt = 4'd3; id_uses_rt = 1'b1;
        step("t3_hz");
        set_idle();
        mem_branch_taken = 1'b1;
        step("t3_flush");
        mem_branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) step("t3_after");

        // HLT: drain, then halted and frozen.
        id_hlt = 1'b1;
        step("t4_hlt");
        id_hlt = 1'b0;
        for (int i = 0; i < 3; i++) step("t4_drain");
        for (int i = 0; i < 20; i++) step("t4_halted");
        chk("t4_halted_flag", 16'(hlt_o[0]), 16'd1);

        // Asynchronous reset while halted.
        do_reset("t6_rst");

        // HLT on the wrong path: branch in the second drain cycle.
        id_hlt = 1'b1;
        step("t5_hlt");
        id_hlt = 1'b0;
        step("t5_drain1");
        mem_branch_taken = 1'b1;
        step("t5_flush");
        mem_branch_taken = 1'b0;
        for (int i = 0; i < 6; i++) step("t5_after");
        chk("t5_not_halted", 16'(hlt_o[1]), 16'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            id_rs = 4'($urandom_range(0, 3));
            id_rt = 4'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_rd = 4'($urandom_range(0, 3));
            ex_regwrite = 1'($urandom_range(0, 1));
            ex_memread = ($urandom_range(0, 2) == 0);
            mem_rd = 4'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_branch_taken = ($urandom_range(0, 11) == 0);
            id_hlt = ($urandom_range(0, 29) == 0);
            step("rnd");
            if ((m_halted[0] && m_halted[1] && $urandom_range(0, 3) == 0) ||
                ($urandom_range(0, 149) == 0)) begin
                do_reset("rnd_rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
